execute_stage_pipe: RTL and testbench
=====================================

// Module: execute_stage_pipe
// PURPOSE
//  Parametrised, registered execute stage: ALU ops, branch/jump resolution and an
//  iterative multiplier, with valid/ready handshakes to decode and memory stages.
//  Sits between the ID/EX and EX/MEM boundaries; owns the EX/MEM result register.
//  Unlike the single-cycle execute block, it stalls upstream and absorbs downstream backpressure.
//  It also supports flush, and reports errors on illegal ops and overflowing branch targets.
// PARAMETERS
//  WIDTH     16  datapath and PC width (>=8, multiple of MUL_BITS)
//  MUL_BITS  4   multiplier bits retired per cycle; MUL latency L_MUL = WIDTH/MUL_BITS
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      reset, synchronous, active-high
//  in_valid   in   1      issue request from decode
//  in_ready   out  1      stage can accept; transfer when in_valid&in_ready at clk edge
//  op         in   4      ALU op (encoding below)
//  a          in   WIDTH  source 1
//  b          in   WIDTH  source 2 (register)
//  imm        in   WIDTH  sign-extended immediate
//  alu_src    in   1      1: src2=imm, 0: src2=b
//  pc         in   WIDTH  PC+2 of issuing instruction
//  branch     in   1      conditional branch
//  br_cond    in   2      00 EQZ, 01 NEZ, 10 LTZ, 11 GEZ (tested on ALU result)
//  jump       in   1      unconditional pc-relative jump
//  jump_reg   in   1      register jump; target = ALU result
//  flush      in   1      kill in-flight and held results
//  out_valid  out  1      EX/MEM register holds a valid result
//  out_ready  in   1      memory stage accepts; transfer when out_valid&out_ready
//  alu_res    out  WIDTH  registered ALU result
//  next_pc    out  WIDTH  registered next PC
//  redirect   out  1      registered: next_pc != sequential (taken branch/jump/jump_reg)
//  err        out  1      registered: illegal op or signed overflow of pc+imm when taken
// BEHAVIOUR
//  Ops: 0 ADD, 1 SUB (a-src2), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift by src2[log2 WIDTH-1:0]),
//   8 SLT signed (1/0), 9 MUL (low WIDTH bits of a*src2), A PASS src2; B-F illegal: res=0, err=1.
//  Add/sub wrap mod 2^WIDTH; no ALU overflow error.
//  taken = jump | (branch & cond(br_cond, res)); LTZ = res[WIDTH-1], EQZ = (res==0).
//  next_pc = jump_reg ? res : taken ? pc+imm : pc; redirect = jump_reg | taken.
//  err = illegal | (taken & signed_ovf(pc+imm)); jump_reg never sets ovf err.
//  FSM: IDLE, MUL_BUSY, HOLD.
//  IDLE: on accept of non-MUL op, write output regs at that edge, so out_valid=1 next cycle (latency 1).
//   The FSM goes to HOLD if out_ready=0 at the following edge.
//  IDLE: on accept of MUL, latch operands, go to MUL_BUSY; shift-add MUL_BITS/cycle.
//   The result is written at edge t+L_MUL (t = accept edge).
//  MUL_BUSY: in_ready=0; out_valid drops once the prior result drains.
//   On completion, if the prior result is still held (out_valid&~out_ready), wait in MUL_BUSY.
//   Then write when the register frees.
//  in_ready = (state!=MUL_BUSY) & (~out_valid | out_ready) & ~flush & ~rst.
//  Simultaneous drain and accept: both occur on the same edge; no bubble.
//  HOLD: outputs stable while out_valid & ~out_ready (no output change, no accept).
//  flush (priority over everything but rst): out_valid<=0, abort MUL, state<=IDLE.
//   An input presented in the flush cycle is dropped; in_ready=0 that cycle.
//  rst: state IDLE, out_valid=0, alu_res=0, next_pc=0, redirect=0, err=0, multiplier cleared.
//   rst mid-MUL aborts with no output.
//  redirect/err are only meaningful while out_valid=1; they are held with data under backpressure.
// TESTING
//  ADD a=0x7FFF imm=0x0001 alu_src=1, out_ready=1 -> next cycle out_valid=1, alu_res=0x8000, err=0.
//  SUB a=b=0x1234, branch=1 br_cond=00, pc=0x0010 imm=0x0004 -> alu_res=0, next_pc=0x0014, redirect=1.
//  MUL a=0x0003 b=0x0005 -> in_ready=0 for 4 cycles, out_valid after edge t+4, alu_res=0x000F.
//   0xFFFF*0x0002 -> 0xFFFE.
//  out_ready=0 for 3 cycles after ADD result -> alu_res/out_valid stable.
//   A MUL issued behind it completes only after the drain.
//  Flush 2 cycles into MUL -> no out_valid; in_ready=1 next cycle; next ADD completes normally.
//  jump=1 pc=0x7FFE imm=0x0004 -> next_pc=0x8002, redirect=1, err=1.
//   Op 0xC -> alu_res=0, err=1. rst asserted mid-MUL -> all outputs 0.

Source files
------------

// File: rtl/execute_stage_pipe.sv
// execute_stage_pipe
//   Registered execute stage sitting between the ID/EX and EX/MEM boundaries.
//   It performs ALU operations and resolves branches and jumps. Multiplies run
//   on an iterative shift-add multiplier that retires MUL_BITS bits per cycle.
//   Valid/ready handshakes are used on both sides. The stage stalls decode
//   while a multiply runs, and it absorbs backpressure from the memory stage.
//
// Ports
//   clk, rst                   clock; synchronous active-high reset
//   in_valid / in_ready        issue handshake from decode
//   op, a, b, imm, alu_src     ALU op and operands (src2 = alu_src ? imm : b)
//   pc                         PC+2 of the issuing instruction
//   branch, br_cond            conditional branch on ALU result (EQZ/NEZ/LTZ/GEZ)
//   jump, jump_reg             pc-relative jump / register jump (target = result)
//   flush                      kill the in-flight multiply and any held result
//   out_valid / out_ready      EX/MEM register handshake to the memory stage
//   alu_res, next_pc           registered result and next PC
//   redirect, err              registered redirect flag; illegal op or target overflow
module execute_stage_pipe #(
  parameter int WIDTH    = 16,
  parameter int MUL_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] pc,
  input  logic             branch,
  input  logic [1:0]       br_cond,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] next_pc,
  output logic             redirect,
  output logic             err
);

  localparam int L_MUL = WIDTH / MUL_BITS;
  localparam int SHW   = $clog2(WIDTH);
  localparam int CW    = $clog2(L_MUL + 1);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, HOLD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] npc;
    logic             redirect;
    logic             ovf_err;
  } ctl_t;

  state_t state, next_state;

  logic [WIDTH-1:0] src2, alu_out;
  logic [SHW-1:0]   shamt;
  logic             illegal_in, slt_bit;
  logic             accept, is_mul, issue_write, mul_write, reg_free;
  ctl_t             in_ctl, mul_ctl;

  // Multiplier state, plus the branch context of the multiply so that it can
  // be resolved on the final product.
  logic [WIDTH-1:0] mul_mcand, mul_mplier, mul_acc, mul_acc_next, mul_partial, mul_result;
  logic [CW-1:0]    mul_cnt;
  logic             mul_done, last_step;
  logic [WIDTH-1:0] m_pc, m_imm;
  logic             m_branch, m_jump, m_jreg;
  logic [1:0]       m_cond;

  // The branch condition is tested on the ALU result. The taken target is
  // pc+imm. It overflows when both addends share a sign and the sum flips it.
  // A register jump uses the result itself as the target, so it never flags
  // an overflow.
  function automatic ctl_t resolve(input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] pc_i,
                                   input logic [WIDTH-1:0] imm_i, input logic branch_i,
                                   input logic [1:0] cond_i, input logic jump_i,
                                   input logic jreg_i);
    logic             cond_ok;
    logic             taken;
    logic [WIDTH-1:0] target;
    ctl_t             r;
    case (cond_i)
      2'b00:   cond_ok = (res == '0);
      2'b01:   cond_ok = (res != '0);
      2'b10:   cond_ok = res[WIDTH-1];
      default: cond_ok = ~res[WIDTH-1];
    endcase
    taken      = jump_i | (branch_i & cond_ok);
    target     = pc_i + imm_i;
    r.npc      = jreg_i ? res : (taken ? target : pc_i);
    r.redirect = jreg_i | taken;
    r.ovf_err  = taken & ~jreg_i & (pc_i[WIDTH-1] == imm_i[WIDTH-1]) &
                 (target[WIDTH-1] != pc_i[WIDTH-1]);
    return r;
  endfunction

  assign src2    = alu_src ? imm : b;
  assign shamt   = src2[SHW-1:0];
  assign slt_bit = $signed(a) < $signed(src2);

  // Single-cycle ALU. MUL never writes the output through this path because
  // its result comes from the multiplier. Ops 0xB-0xF are illegal; they give
  // a zero result.
  always_comb begin
    alu_out    = '0;
    illegal_in = 1'b0;
    case (op)
      4'h0:    alu_out = a + src2;
      4'h1:    alu_out = a - src2;
      4'h2:    alu_out = a & src2;
      4'h3:    alu_out = a | src2;
      4'h4:    alu_out = a ^ src2;
      4'h5:    alu_out = a << shamt;
      4'h6:    alu_out = a >> shamt;
      4'h7:    alu_out = $signed(a) >>> shamt;
      4'h8:    alu_out = {{(WIDTH-1){1'b0}}, slt_bit};
      4'h9:    alu_out = '0;
      4'hA:    alu_out = src2;
      default: illegal_in = 1'b1;
    endcase
  end

  assign in_ctl = resolve(alu_out, pc, imm, branch, br_cond, jump, jump_reg);

  // Each step multiplies the low MUL_BITS of the multiplier by the shifted
  // multiplicand. Once the last step has been taken, the product is parked in
  // mul_acc until the output register is free.
  assign mul_partial  = mul_mcand * {{(WIDTH-MUL_BITS){1'b0}}, mul_mplier[MUL_BITS-1:0]};
  assign mul_acc_next = mul_acc + mul_partial;
  assign last_step    = ~mul_done & (mul_cnt == CW'(L_MUL - 1));
  assign mul_result   = mul_done ? mul_acc : mul_acc_next;
  assign mul_ctl      = resolve(mul_result, m_pc, m_imm, m_branch, m_cond, m_jump, m_jreg);

  assign reg_free    = ~out_valid | out_ready;
  assign accept      = in_valid & in_ready;
  assign is_mul      = (op == 4'h9);
  assign issue_write = accept & ~is_mul;
  assign mul_write   = (state == MUL_BUSY) & (mul_done | last_step) & reg_free;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic. A flush always returns the stage to IDLE. HOLD marks a
  // result that stayed in the register because out_ready was low at the
  // last edge.
  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept & is_mul)              next_state = MUL_BUSY;
          else if (out_valid & ~out_ready)  next_state = HOLD;
          else                              next_state = IDLE;
        end
        MUL_BUSY: if (mul_write) next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  // Output logic. The stage takes a new instruction only when no multiply is
  // running and the result register is either empty or draining this edge.
  always_comb begin
    in_ready = (state != MUL_BUSY) & reg_free & ~flush & ~rst;
  end

  // EX/MEM result register and multiplier datapath. A drain and a new write
  // can happen on the same edge, so no bubble is inserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_res    <= '0;
      next_pc    <= '0;
      redirect   <= 1'b0;
      err        <= 1'b0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_acc    <= '0;
      mul_cnt    <= '0;
      mul_done   <= 1'b0;
      m_pc       <= '0;
      m_imm      <= '0;
      m_branch   <= 1'b0;
      m_cond     <= 2'b00;
      m_jump     <= 1'b0;
      m_jreg     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      mul_cnt   <= '0;
      mul_done  <= 1'b0;
    end else begin
      if (issue_write) begin
        out_valid <= 1'b1;
        alu_res   <= alu_out;
        next_pc   <= in_ctl.npc;
        redirect  <= in_ctl.redirect;
        err       <= illegal_in | in_ctl.ovf_err;
      end else if (mul_write) begin
        out_valid <= 1'b1;
        alu_res   <= mul_result;
        next_pc   <= mul_ctl.npc;
        redirect  <= mul_ctl.redirect;
        err       <= mul_ctl.ovf_err;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept & is_mul) begin
        mul_mcand  <= a;
        mul_mplier <= src2;
        mul_acc    <= '0;
        mul_cnt    <= '0;
        mul_done   <= 1'b0;
        m_pc       <= pc;
        m_imm      <= imm;
        m_branch   <= branch;
        m_cond     <= br_cond;
        m_jump     <= jump;
        m_jreg     <= jump_reg;
      end else if ((state == MUL_BUSY) & ~mul_done) begin
        mul_mcand  <= mul_mcand << MUL_BITS;
        mul_mplier <= mul_mplier >> MUL_BITS;
        mul_acc    <= mul_acc_next;
        mul_cnt    <= mul_cnt + CW'(1);
        if (last_step) mul_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_pipe.sv
// tb_execute_stage_pipe
//   Scoreboard bench for execute_stage_pipe. The driver pushes the expected
//   result of every accepted instruction. An independent monitor pops and
//   compares the expected result on each output transfer. Expected results
//   come from a plain-arithmetic model of the instruction semantics.
module tb_execute_stage_pipe;

  localparam int W = 16;
  localparam int L = 4;

  typedef struct {
    logic [15:0] res;
    logic [15:0] npc;
    logic        redir;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, alu_src, branch, jump, jump_reg, flush;
  logic        out_valid, out_ready, redirect, err;
  logic [3:0]  op;
  logic [1:0]  br_cond;
  logic [15:0] a, b, imm, pc, alu_res, next_pc;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  execute_stage_pipe #(.WIDTH(W), .MUL_BITS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .imm(imm), .alu_src(alu_src), .pc(pc), .branch(branch),
    .br_cond(br_cond), .jump(jump), .jump_reg(jump_reg), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_res(alu_res),
    .next_pc(next_pc), .redirect(redirect), .err(err)
  );

  always #5 clk = ~clk;

  // Instruction semantics computed with integer arithmetic.
  function automatic exp_t refModel(input logic [3:0] o, input logic [15:0] aa, bb, ii,
                                    input logic src, input logic [15:0] p, input logic br,
                                    input logic [1:0] c, input logic j, jr);
    exp_t        e;
    logic [15:0] s;
    int          sa, ss, r, sh, t;
    longint      prod;
    logic        illegal, cond_ok, taken, ovf;
    s       = src ? ii : bb;
    sa      = $signed(aa);
    ss      = $signed(s);
    sh      = int'(s[3:0]);
    illegal = 1'b0;
    r       = 0;
    case (o)
      4'h0: r = sa + ss;
      4'h1: r = sa - ss;
      4'h2: r = int'({16'h0, aa & s});
      4'h3: r = int'({16'h0, aa | s});
      4'h4: r = int'({16'h0, aa ^ s});
      4'h5: r = int'({16'h0, aa}) << sh;
      4'h6: r = int'({16'h0, aa}) >> sh;
      4'h7: r = sa >>> sh;
      4'h8: r = (sa < ss) ? 1 : 0;
      4'h9: begin
        prod = longint'({16'h0, aa}) * longint'({16'h0, s});
        r    = int'(prod % 65536);
      end
      4'hA: r = int'({16'h0, s});
      default: illegal = 1'b1;
    endcase
    e.res = r[15:0];
    case (c)
      2'b00:   cond_ok = (e.res == 16'h0);
      2'b01:   cond_ok = (e.res != 16'h0);
      2'b10:   cond_ok = e.res[15];
      default: cond_ok = !e.res[15];
    endcase
    taken   = j || (br && cond_ok);
    t       = int'($signed(p)) + int'($signed(ii));
    ovf     = (t > 32767) || (t < -32768);
    e.npc   = jr ? e.res : (taken ? t[15:0] : p);
    e.redir = jr || taken;
    e.err   = illegal || (taken && !jr && ovf);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [15:0] aa, bb, ii,
                               input logic src, input logic [15:0] p, input logic br,
                               input logic [1:0] c, input logic j, jr);
    op = o; a = aa; b = bb; imm = ii; alu_src = src; pc = p;
    branch = br; br_cond = c; jump = j; jump_reg = jr;
    in_valid = 1'b1;
  endtask

  // One cycle. Inputs were set just after the falling edge; sample them 3ns
  // later, record an accept, then move on to the next falling edge.
  task automatic tick(output logic acc);
    #3;
    acc = 1'b0;
    if (rst === 1'b1 || flush === 1'b1) begin
      checkOutput("in_ready_blocked", {31'h0, in_ready}, 32'h0);
      sb.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b0)
        checkOutput("in_ready_held", {31'h0, in_ready}, 32'h0);
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        acc = 1'b1;
        sb.push_back(refModel(op, a, b, imm, alu_src, pc, branch, br_cond, jump, jump_reg));
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] aa, bb, ii, input logic src,
                       input logic [15:0] p, input logic br, input logic [1:0] c,
                       input logic j, jr);
    logic acc;
    int   n;
    applyStimulus(o, aa, bb, ii, src, p, br, c, j, jr);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 40) begin
      tick(acc);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("[TB] FAIL issue_timeout: op %0h not accepted in %0d cycles", o, n);
    end
  endtask

  // Count the idle cycles, and the cycles with in_ready low, until out_valid
  // is seen. The search stops after a fixed number of cycles.
  task automatic waitOut(input int limit, output int n, output int lowReady, output logic seen);
    seen = 1'b0; n = 0; lowReady = 0;
    while (!seen && n < limit) begin
      #3;
      if (out_valid === 1'b1) seen = 1'b1;
      else begin
        n++;
        if (in_ready === 1'b0) lowReady++;
      end
      @(negedge clk);
    end
  endtask

  // Monitor. On every output transfer it pops the oldest expected result and
  // compares it. While a result is held under backpressure it checks that the
  // outputs do not move.
  initial begin
    exp_t        e;
    logic [15:0] hr, hn;
    logic        hrd, he, heldPrev;
    heldPrev = 1'b0;
    hr = '0; hn = '0; hrd = 1'b0; he = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (rst === 1'b1 || flush === 1'b1) begin
        heldPrev = 1'b0;
      end else begin
        if (heldPrev) begin
          total++;
          if (out_valid !== 1'b1 || alu_res !== hr || next_pc !== hn || redirect !== hrd || err !== he) begin
            bad++;
            $display("[TB] FAIL hold_stable: got v=%b res=%h npc=%h rd=%b err=%b want v=1 res=%h npc=%h rd=%b err=%b",
                     out_valid, alu_res, next_pc, redirect, err, hr, hn, hrd, he);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_output: got res=%h npc=%h want no output", alu_res, next_pc);
          end else begin
            e = sb.pop_front();
            if (alu_res !== e.res || next_pc !== e.npc || redirect !== e.redir || err !== e.err) begin
              bad++;
              $display("[TB] FAIL result: got res=%h npc=%h rd=%b err=%b want res=%h npc=%h rd=%b err=%b",
                       alu_res, next_pc, redirect, err, e.res, e.npc, e.redir, e.err);
            end
          end
        end
        heldPrev = (out_valid === 1'b1 && out_ready === 1'b0);
        hr = alu_res; hn = next_pc; hrd = redirect; he = err;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc, seen;
    int   n, low;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; imm = '0; alu_src = 1'b0; pc = '0;
    branch = 1'b0; br_cond = 2'b00; jump = 1'b0; jump_reg = 1'b0;

    // Reset state.
    @(negedge clk);
    tick(acc);
    tick(acc);
    rst = 1'b0;
    #3;
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_alu_res", {16'h0, alu_res}, 32'h0);
    checkOutput("rst_next_pc", {16'h0, next_pc}, 32'h0);
    checkOutput("rst_flags", {30'h0, redirect, err}, 32'h0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);

    // ADD with signed wrap: one-cycle latency, no error.
    issue(4'h0, 16'h7FFF, 16'h0000, 16'h0001, 1'b1, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0);
    waitOut(10, n, low, seen);
    checkOutput("add_latency", n, 0);

    // SUB to zero with a taken EQZ branch.
    issue(4'h1, 16'h1234, 16'h1234, 16'h0004, 1'b0, 16'h0010, 1'b1, 2'b00, 1'b0, 1'b0);
    waitOut(10, n, low, seen);

    // MUL 3*5: stalls decode for L cycles and the result appears after edge t+L.
    issue(4'h9, 16'h0003, 16'h0005, 16'h0000, 1'b0, 16'h0002, 1'b0, 2'b00, 1'b0, 1'b0);
    waitOut(12, n, low, seen);
    checkOutput("mul_latency", n, L);
    checkOutput("mul_stall", low, L);
    issue(4'h9, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 16'h0004, 1'b0, 2'b00, 1'b0, 1'b0);
    waitOut(12, n, low, seen);

    // Backpressure: the ADD result is held for several cycles. The MUL
    // behind it can enter only on the drain edge.
    out_ready = 1'b0;
    issue(4'h0, 16'h1111, 16'h2222, 16'h0000, 1'b0, 16'h0100, 1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(4'h9, 16'h0007, 16'h0009, 16'h0000, 1'b0, 16'h0200, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      checkOutput("bp_no_accept", {31'h0, acc}, 32'h0);
    end
    out_ready = 1'b1;
    tick(acc);
    checkOutput("bp_drain_accept", {31'h0, acc}, 32'h1);
    in_valid = 1'b0;
    waitOut(12, n, low, seen);
    checkOutput("bp_mul_latency", n, L);

    // Flush two cycles into a MUL. An instruction presented with the flush
    // is dropped.
    issue(4'h9, 16'h0123, 16'h0456, 16'h0000, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(acc);
    flush = 1'b1;
    applyStimulus(4'h0, 16'h0001, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    #3;
    checkOutput("flush_ready_after", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    waitOut(8, n, low, seen);
    checkOutput("flush_no_output", {31'h0, seen}, 32'h0);
    issue(4'h0, 16'h0040, 16'h0002, 16'h0000, 1'b0, 16'h0030, 1'b0, 2'b00, 1'b0, 1'b0);
    waitOut(10, n, low, seen);
    checkOutput("post_flush_add", n, 0);

    // Taken jump whose target overflows, then an illegal op.
    issue(4'h0, 16'h0001, 16'h0001, 16'h0004, 1'b0, 16'h7FFE, 1'b0, 2'b00, 1'b1, 1'b0);
    waitOut(10, n, low, seen);
    issue(4'hC, 16'h5555, 16'h3333, 16'h0000, 1'b0, 16'h0008, 1'b0, 2'b00, 1'b0, 1'b0);
    waitOut(10, n, low, seen);

    // Reset in the middle of a MUL clears every output.
    issue(4'h9, 16'h00FF, 16'h0011, 16'h0000, 1'b0, 16'h0010, 1'b0, 2'b00, 1'b0, 1'b0);
    tick(acc);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    #3;
    checkOutput("rst_mid_mul_outs", {alu_res, next_pc}, 32'h0);
    checkOutput("rst_mid_mul_flags", {29'h0, out_valid, redirect, err}, 32'h0);
    @(negedge clk);
    waitOut(8, n, low, seen);
    checkOutput("rst_mid_mul_silent", {31'h0, seen}, 32'h0);

    // Random traffic with random backpressure and occasional flushes.
    acc = 1'b1;
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 59) == 0);
      if (!in_valid || acc) begin
        logic [15:0] ra, rb, rimm;
        int          k, sel;
        sel = $urandom_range(0, 4);
        ra  = (sel == 0) ? 16'h7FFF : (sel == 1) ? 16'h8000 : (sel == 2) ? 16'hFFFF : 16'($urandom);
        rb  = 16'($urandom);
        rimm = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(int'($urandom_range(0, 31)) - 16);
        k   = $urandom_range(0, 4);
        applyStimulus(($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 15)),
                      ra, rb, rimm, 1'($urandom_range(0, 1)), 16'($urandom) & 16'hFFFE,
                      (k == 1 || k == 4), 2'($urandom_range(0, 3)), (k == 2), (k == 3));
        in_valid = ($urandom_range(0, 9) < 6);
      end
      tick(acc);
    end

    // Drain whatever is still in flight.
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() > 0; i++) tick(acc);
    repeat (2) @(negedge clk);
    checkOutput("drain_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
